// File: rtl/ifetch_unit.sv
// Instruction fetch stage: requests 4-word lines from the I-cache and writes them whole into
// the IFQ. It tracks IFQ occupancy locally and flushes on CDB redirects.
`timescale 1ns/1ps
module ifetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                LINE_W   = 128,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_valid,
    input  logic [LINE_W-1:0] icache_rdata,
    output logic              if_w_en,
    output logic [LINE_W-1:0] if_w_din,
    input  logic              du_r_en,
    output logic              ifq_flush,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        redirect_off,
    output logic [1:0]        dbg_state,
    output logic [4:0]        dbg_occ
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        occ;
    logic [4:0]        occ_next;
    logic [LINE_W-1:0] hold_line;
    logic              space;
    logic              req;
    logic              wen;
    logic              rd;
    logic [LINE_W-1:0] din;

    // Strobe semantics: icache_req, icache_valid, if_w_en and ifq_flush are single-cycle
    // pulses with no back-pressure. A request is accepted when pulsed, and a response or write
    // takes effect in the same cycle as its strobe.
    assign space = (occ <= 5'd12);
    assign rd    = du_r_en && (occ != 5'd0);

    always_comb begin
        state_next = state;
        req        = 1'b0;
        wen        = 1'b0;
        din        = '0;
        if (redirect_valid) begin
            // A response still owed by the cache must be swallowed before fetching again.
            if ((state == S_WAIT || state == S_DRAIN) && !icache_valid) begin
                state_next = S_DRAIN;
            end else begin
                state_next = S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (space) begin
                        req        = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_valid) begin
                        if (space) begin
                            wen        = 1'b1;
                            din        = icache_rdata;
                            state_next = S_RUN;
                        end else begin
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (space) begin
                        wen        = 1'b1;
                        din        = hold_line;
                        state_next = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (icache_valid) begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_RUN;
            endcase
        end
    end

    assign occ_next = occ + {2'b00, wen, 2'b00} - {4'b0000, rd};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_RUN;
            pc           <= RESET_PC;
            occ          <= 5'd0;
            redirect_off <= 2'd0;
            hold_line    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc           <= {redirect_pc[ADDR_W-1:4], 4'b0000};
                redirect_off <= redirect_pc[3:2];
                occ          <= 5'd0;
            end else begin
                occ <= occ_next;
                if (wen) begin
                    pc <= pc + ADDR_W'(16);
                end
                if (state == S_WAIT && icache_valid && !space) begin
                    hold_line <= icache_rdata;
                end
            end
        end
    end

    // Strobes are masked while reset is held so the idle RUN state does not request.
    assign icache_req  = req && reset;
    assign icache_addr = pc;
    assign if_w_en     = wen && reset;
    assign if_w_din    = reset ? din : '0;
    assign ifq_flush   = redirect_valid && reset;
    assign dbg_state   = state;
    assign dbg_occ     = occ;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random DU reads, cache latencies and
// redirects, checked each cycle against a transaction-level model of the fetch stage.
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic         clk;
    logic         reset;
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic         icache_valid;
    logic [127:0] icache_rdata;
    logic         if_w_en;
    logic [127:0] if_w_din;
    logic         du_r_en;
    logic         ifq_flush;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [1:0]   redirect_off;
    logic [1:0]   dbg_state;
    logic [4:0]   dbg_occ;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_valid   (icache_valid),
        .icache_rdata   (icache_rdata),
        .if_w_en        (if_w_en),
        .if_w_din       (if_w_din),
        .du_r_en        (du_r_en),
        .ifq_flush      (ifq_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_off   (redirect_off),
        .dbg_state      (dbg_state),
        .dbg_occ        (dbg_occ)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard counters and model state
    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] exp_q[$];      // lines accepted from the cache, not yet written to the IFQ
    logic [31:0]  m_pc;
    int           m_occ;
    logic [1:0]   m_off;
    logic         m_busy;        // a cache response is still owed
    logic         m_want;        // that response is to be kept
    int           resp_cnt;      // cycles until the owed response is strobed
    int           lat;           // 0 selects a random latency of 1..3

    // observations for directed checks
    int           n_req;
    int           n_wen;
    logic [31:0]  last_req_addr;
    logic         saw_flush;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc     = 32'h0;
        m_occ    = 0;
        m_off    = 2'd0;
        m_busy   = 1'b0;
        m_want   = 1'b0;
        resp_cnt = 0;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input logic du, input logic rv, input logic [31:0] rpc);
        logic         space;
        logic         incoming;
        logic         e_req;
        logic         e_wen;
        logic [127:0] e_din;
        du_r_en        = du;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_valid   = (resp_cnt == 1);
        icache_rdata   = {$urandom, $urandom, $urandom, $urandom};
        if (resp_cnt > 0) resp_cnt--;
        #1;
        space    = (m_occ <= 12);
        incoming = icache_valid && m_busy && m_want;
        e_req    = 1'b0;
        e_wen    = 1'b0;
        e_din    = '0;
        if (!rv) begin
            if (exp_q.size() > 0) begin
                e_wen = space;
                e_din = exp_q[0];
            end else if (incoming) begin
                e_wen = space;
                e_din = icache_rdata;
            end else if (!m_busy) begin
                e_req = space;
            end
        end
        check("req", icache_req, e_req);
        if (e_req) check("addr", icache_addr, m_pc);
        check("wen", if_w_en, e_wen);
        if (e_wen) check("din", if_w_din, e_din);
        check("flush", ifq_flush, rv);
        check("off", redirect_off, m_off);
        check("occ", dbg_occ, m_occ);
        if (icache_req) begin
            n_req++;
            last_req_addr = icache_addr;
        end
        if (if_w_en) n_wen++;
        if (ifq_flush) saw_flush = 1'b1;
        if (rv) begin
            m_pc  = {rpc[31:4], 4'b0000};
            m_off = rpc[3:2];
            m_occ = 0;
            exp_q.delete();
            m_want = 1'b0;
            if (icache_valid) m_busy = 1'b0;
        end else begin
            m_occ = m_occ + (e_wen ? 4 : 0) - ((du && m_occ != 0) ? 1 : 0);
            if (e_wen) begin
                m_pc = m_pc + 32'd16;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (icache_valid && m_busy) begin
                m_busy = 1'b0;
                if (m_want && !e_wen) exp_q.push_back(icache_rdata);
            end
            if (e_req) begin
                m_busy   = 1'b1;
                m_want   = 1'b1;
                resp_cnt = (lat != 0) ? lat : int'($urandom_range(1, 3));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        icache_valid   = 1'b0;
        icache_rdata   = '0;
        du_r_en        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        n_req          = 0;
        n_wen          = 0;
        last_req_addr  = '0;
        saw_flush      = 1'b0;
        lat            = 1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // fill the IFQ from empty with a 1-cycle cache
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        check("t1_reqs", n_req, 4);
        check("t1_occ", dbg_occ, 16);

        // four DU reads reopen space; the next line is requested
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        lat   = 3;
        n_req = 0;
        step(1'b0, 1'b0, 32'h0);
        check("t2_addr", last_req_addr, 32'h40);

        // occupancy raised while the line is in flight: the line waits for space
        force dut.occ = 5'd16;
        m_occ = 16;
        n_wen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        release dut.occ;
        check("t3_no_wr_full", n_wen, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        check("t3_hold_wr", n_wen, 1);

        // redirect while waiting: late response is discarded
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        saw_flush = 1'b0;
        n_wen     = 0;
        n_req     = 0;
        step(1'b0, 1'b1, 32'h1238);
        check("t4_flush", saw_flush, 1);
        check("t4_off", redirect_off, 2);
        check("t4_occ", dbg_occ, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        check("t4_no_wr", n_wen, 0);
        check("t4_addr", last_req_addr, 32'h1230);

        // redirect coincident with the response
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        lat = 1;
        step(1'b0, 1'b0, 32'h0);
        n_wen = 0;
        step(1'b0, 1'b1, 32'h2004);
        check("t5_no_wr", n_wen, 0);
        step(1'b0, 1'b0, 32'h0);
        check("t5_addr", last_req_addr, 32'h2000);

        // reset asserted mid-request
        step(1'b0, 1'b0, 32'h0);
        lat = 3;
        step(1'b0, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        check("t6_req", icache_req, 0);
        check("t6_addr", icache_addr, 32'h0);
        check("t6_wen", if_w_en, 0);
        check("t6_din", if_w_din, 0);
        check("t6_flush", ifq_flush, 0);
        check("t6_off", redirect_off, 0);
        check("t6_occ", dbg_occ, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        n_req = 0;
        step(1'b0, 1'b0, 32'h0);
        check("t6_first_req", n_req, 1);
        check("t6_first_addr", last_req_addr, 32'h0);

        // random traffic
        lat = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 $urandom & 32'hffff_fffc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
